// File: rtl/sdes_key_scheduler_if.sv
// Handshake bundle between the S-DES key scheduler and its key-load / round-datapath neighbours.
interface sdes_key_scheduler_if;
  logic       key_valid;
  logic [9:0] key;
  logic       key_ready;
  logic       run;
  logic       decrypt;
  logic       sched_valid;
  logic       busy;
  logic       rk_valid;
  logic [7:0] rk;
  logic       rk_last;
  logic       rk_ack;
  logic       run_err;

  // Driver side: key loader and round datapath.
  modport master (
    output key_valid, key, run, decrypt, rk_ack,
    input  key_ready, sched_valid, busy, rk_valid, rk, rk_last, run_err
  );

  // Scheduler side.
  modport slave (
    input  key_valid, key, run, decrypt, rk_ack,
    output key_ready, sched_valid, busy, rk_valid, rk, rk_last, run_err
  );
endinterface

// File: rtl/sdes_key_scheduler.sv
// Iterative S-DES key schedule: derives K1/K2 with a rotating {L,R} register over several
// cycles, then serves the two round keys in encrypt or decrypt order under valid/ack.
module sdes_key_scheduler #(
  parameter bit SINGLE_SHIFT = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  sdes_key_scheduler_if.slave  bus
);

  typedef enum logic [2:0] {StIdle, StLs1, StLs2a, StLs2b, StRk0, StRk1} state_e;

  state_e     state_q, state_d;
  logic [4:0] l_q, l_d, r_q, r_d;
  logic [7:0] k1_q, k1_d, k2_q, k2_d;
  logic       mode_q, mode_d;
  logic       sched_valid_q, sched_valid_d;
  logic       run_err_q, run_err_d;

  logic [9:0] p10_key;
  logic [4:0] l_rot1, r_rot1, l_rot2, r_rot2;

  // Bit k(n) of the standard numbering lives at index 10-n.
  function automatic logic [7:0] p8(input logic [9:0] lr);
    return {lr[4], lr[7], lr[3], lr[6], lr[2], lr[5], lr[0], lr[1]};
  endfunction

  assign p10_key = {bus.key[7], bus.key[5], bus.key[8], bus.key[3], bus.key[6],
                    bus.key[0], bus.key[9], bus.key[1], bus.key[2], bus.key[4]};

  assign l_rot1 = {l_q[3:0], l_q[4]};
  assign r_rot1 = {r_q[3:0], r_q[4]};
  assign l_rot2 = {l_q[2:0], l_q[4:3]};
  assign r_rot2 = {r_q[2:0], r_q[4:3]};

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  // Next-state logic; key load takes priority over run in IDLE.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (bus.key_valid)                    state_d = StLs1;
        else if (bus.run && sched_valid_q)    state_d = StRk0;
      end
      StLs1:   state_d = StLs2a;
      StLs2a:  state_d = SINGLE_SHIFT ? StLs2b : StIdle;
      StLs2b:  state_d = StIdle;
      StRk0:   if (bus.rk_ack) state_d = StRk1;
      StRk1:   if (bus.rk_ack) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Datapath next-state: shift register, subkey capture, order latch and error pulse.
  always_comb begin
    l_d           = l_q;
    r_d           = r_q;
    k1_d          = k1_q;
    k2_d          = k2_q;
    mode_d        = mode_q;
    sched_valid_d = sched_valid_q;
    run_err_d     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.key_valid) begin
          {l_d, r_d}    = p10_key;
          sched_valid_d = 1'b0;
          run_err_d     = bus.run;  // run colliding with a key load is dropped
        end else if (bus.run) begin
          if (sched_valid_q) mode_d    = bus.decrypt;
          else               run_err_d = 1'b1;
        end
      end
      StLs1: begin
        l_d  = l_rot1;
        r_d  = r_rot1;
        k1_d = p8({l_rot1, r_rot1});
      end
      StLs2a: begin
        if (SINGLE_SHIFT) begin
          l_d = l_rot1;
          r_d = r_rot1;
        end else begin
          l_d           = l_rot2;
          r_d           = r_rot2;
          k2_d          = p8({l_rot2, r_rot2});
          sched_valid_d = 1'b1;
        end
      end
      StLs2b: begin
        l_d           = l_rot1;
        r_d           = r_rot1;
        k2_d          = p8({l_rot1, r_rot1});
        sched_valid_d = 1'b1;
      end
      default: ;
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      l_q           <= '0;
      r_q           <= '0;
      k1_q          <= '0;
      k2_q          <= '0;
      mode_q        <= 1'b0;
      sched_valid_q <= 1'b0;
      run_err_q     <= 1'b0;
    end else begin
      l_q           <= l_d;
      r_q           <= r_d;
      k1_q          <= k1_d;
      k2_q          <= k2_d;
      mode_q        <= mode_d;
      sched_valid_q <= sched_valid_d;
      run_err_q     <= run_err_d;
    end
  end

  // Outputs decoded purely from registered state, so rk has no input-to-output path.
  always_comb begin
    bus.key_ready   = (state_q == StIdle);
    bus.busy        = (state_q != StIdle);
    bus.sched_valid = sched_valid_q;
    bus.run_err     = run_err_q;
    bus.rk_valid    = 1'b0;
    bus.rk_last     = 1'b0;
    bus.rk          = '0;
    unique case (state_q)
      StRk0: begin
        bus.rk_valid = 1'b1;
        bus.rk       = mode_q ? k2_q : k1_q;
      end
      StRk1: begin
        bus.rk_valid = 1'b1;
        bus.rk_last  = 1'b1;
        bus.rk       = mode_q ? k1_q : k2_q;
      end
      default: ;
    endcase
  end

endmodule

// File: doc/sdes_key_scheduler.md
# sdes_key_scheduler

Sequential key-schedule engine and round-key sequencer for the iterative S-DES core. It accepts a 10-bit key over a valid/ready handshake and computes subkeys K1 and K2 over several cycles with a shift register instead of a flat combinational network. It then serves the two round keys, in encrypt or decrypt order, to the round datapath under a valid/ack handshake. It sits between the key-load path and the Feistel round unit.

## Interface
- `SINGLE_SHIFT`, default 1, meaning: 1 = the LS-2 step takes two 1-bit rotate cycles; 0 = LS-2 is a single 2-bit rotate cycle.
- `clk` in 1: the only clock; all state updates on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `key_valid` in 1: a new 10-bit key is offered.
- `key` in 10: the key; `key[9]` is k1 in standard S-DES numbering, `key[0]` is k10.
- `key_ready` out 1: the block can accept a key; high only in IDLE.
- `run` in 1: request for one round-key sequence.
- `decrypt` in 1: order select, sampled when `run` is accepted.
- `sched_valid` out 1: K1 and K2 hold the schedule of the last accepted key.
- `busy` out 1: state is not IDLE.
- `rk_valid` out 1: `rk` carries a round key for the datapath.
- `rk` out 8: the round key.
- `rk_last` out 1: `rk` is the final (second) round key.
- `rk_ack` in 1: the datapath has consumed `rk`.
- `run_err` out 1: one-cycle pulse when `run` is rejected.

## Operation
- Bit permutations, listed MSB first:
  - P10 = (3,5,2,7,4,10,1,9,8,6).
  - P8 picks (6,3,7,4,8,5,10,9) from the 10-bit {L,R}.
  - L and R are 5-bit halves; each rotates left independently.
- Internal registers:
  - `L` and `R`, 5 bits each.
  - `K1` and `K2`, 8 bits each.
  - `mode`, 1 bit.
  - `state`.
- FSM states: IDLE, LS1, LS2A, LS2B (present only when `SINGLE_SHIFT`=1), RK0, RK1.
- **IDLE:**
  - Key accept when `key_valid`=1 (`key_ready`=1):
    - {L,R} <= P10(`key`).
    - `sched_valid` <= 0.
    - Go to LS1.
  - Else if `run`=1 and `sched_valid`=1:
    - `mode` <= `decrypt`.
    - Go to RK0.
  - Else if `run`=1 and `sched_valid`=0: pulse `run_err`, stay in IDLE.
  - Simultaneous `key_valid` and `run`: the key load wins, `run` is dropped, and `run_err` pulses.
- **LS1:**
  - L and R each rotate left by 1.
  - K1 <= P8 of the rotated {L,R}.
  - Go to LS2A.
- **LS2A:**
  - `SINGLE_SHIFT`=1: rotate L and R by 1, go to LS2B.
  - `SINGLE_SHIFT`=0: rotate by 2, K2 <= P8 of the result, `sched_valid` <= 1, go to IDLE.
- **LS2B:**
  - Rotate L and R by 1.
  - K2 <= P8 of the result.
  - `sched_valid` <= 1.
  - Go to IDLE.
- **RK0:**
  - Outputs: `rk_valid`=1, `rk_last`=0, `rk` = `mode` ? K2 : K1.
  - On `rk_ack`, go to RK1.
- **RK1:**
  - Outputs: `rk_valid`=1, `rk_last`=1, `rk` = `mode` ? K1 : K2.
  - On `rk_ack`, go to IDLE.
- `rk_valid`, `rk`, and `rk_last` are decoded from registered state and registered K1/K2/`mode`. No combinational path exists from any input to `rk`.
- `rk_ack` is ignored while `rk_valid`=0.
- `key_valid`, `run`, and `decrypt` are ignored outside IDLE.
- K1 and K2 keep their last values after a sequence completes, so repeated `run` pulses need no reload.

## Timing
- Reset values:
  - State: IDLE.
  - Registers: L, R, K1, K2, `mode` = 0.
  - Outputs: `sched_valid`=0, `busy`=0, `rk_valid`=0, `rk`=0, `rk_last`=0, `run_err`=0, `key_ready`=1 (driven as state==IDLE).
- Reset mid-operation: the next cycle is IDLE with `sched_valid`=0. Any round-key sequence in progress is abandoned without a final ack.
- Key schedule latency, with the key accept edge as edge 0:
  - K1 is valid after edge 1.
  - `SINGLE_SHIFT`=1: K2 and `sched_valid`=1 after edge 3; `key_ready`=1 again in the same cycle.
  - `SINGLE_SHIFT`=0: K2 and `sched_valid`=1 after edge 2.
- Back-to-back keys: the next key can be accepted in the first cycle `key_ready` is high again. This gives a throughput of one key per 4 cycles (3 when `SINGLE_SHIFT`=0).
- `run` accept (edge 0): `rk_valid`=1 after edge 0.
  - Each round key is held stable until its `rk_ack`.
  - With `rk_ack` held high, RK0 and RK1 each last one cycle, and IDLE returns after edge 2.
- `run_err` is high for exactly the cycle after the rejected `run` edge.
- `busy` = !`key_ready`.

## Test plan
- Reset, then load key 10'b1010000010 (`SINGLE_SHIFT`=1) -> K1 = 8'b10100100 (0xA4) after edge 1; `sched_valid` rises after edge 3 with K2 = 8'b01000011 (0x43).
- After the load above, `run` with `decrypt`=0 and `rk_ack` tied high -> `rk` = 0xA4 (`rk_last`=0), then 0x43 (`rk_last`=1), then IDLE; with `decrypt`=1 the order is 0x43 then 0xA4.
- Backpressure: `rk_ack` low for 5 cycles in RK0 -> `rk` and `rk_valid` stay stable; a single `rk_ack` advances exactly one key.
- `run` after reset with no key loaded -> one-cycle `run_err`, `rk_valid` stays 0; simultaneous `key_valid` and `run` -> key accepted, `run_err` pulses.
- Keys 10'h000 and 10'h3FF -> K1=K2=0x00 and K1=K2=0xFF respectively; repeat the 0x282 vector with `SINGLE_SHIFT`=0 -> same keys, `sched_valid` one cycle earlier.
- Assert `rst` in LS2A and again in RK1 -> IDLE next cycle, `sched_valid`=0, `rk_valid`=0; a subsequent `run` produces `run_err`.
